// File: rtl/ysyx_24080006_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 master read channel between N
// requesters (0 = IFU, 1 = LSU, others spare). One transaction (AR plus
// the whole R burst) is in flight at a time. Returning bursts are checked
// for length and ID errors; err is sticky until reset.
//
// Handshake rules: a transfer happens on a cycle where valid and ready are
// both high. A requester holds s_arvalid and its fields until it sees its
// s_arready bit. The master side holds m_arvalid and the AR fields until
// m_arready. R beats pass straight through, so the granted requester's
// s_rready drives m_rready and m_rvalid drives its s_rvalid bit.
module ysyx_24080006_axi_rd_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      s_arvalid,
    output logic [N-1:0]      s_arready,
    input  logic [N*32-1:0]   s_araddr,
    input  logic [N*8-1:0]    s_arlen,
    input  logic [N*3-1:0]    s_arsize,
    output logic [N-1:0]      s_rvalid,
    input  logic [N-1:0]      s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [31:0]       m_araddr,
    output logic [IDW-1:0]    m_arid,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic [IDW-1:0]    m_rid,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int GW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   pick;
    logic            pick_found;
    logic [31:0]     pick_addr;
    logic [7:0]      pick_len;
    logic [2:0]      pick_size;
    logic [8:0]      beat_cnt;
    logic            r_hs;

    // Round-robin search upward from last_grant+1, wrapping modulo N
    always_comb begin
        pick       = last_grant;
        pick_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int cand;
            cand = (int'(last_grant) + k) % N;
            if (!pick_found && s_arvalid[cand]) begin
                pick_found = 1'b1;
                pick       = GW'(cand);
            end
        end
    end

    // Select the winning requester's AR fields out of the packed buses
    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        pick_size = '0;
        for (int i = 0; i < N; i++) begin
            if (GW'(i) == pick) begin
                pick_addr = s_araddr[i*32 +: 32];
                pick_len  = s_arlen[i*8 +: 8];
                pick_size = s_arsize[i*3 +: 3];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pick_found) state_next = ADDR;
            ADDR: if (m_arready) state_next = DATA;
            DATA: if (m_rvalid && m_rready && m_rlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Channel outputs; everything is forced low while reset is held so a
    // beat arriving during reset is never accepted
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        m_arvalid = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    for (int i = 0; i < N; i++) begin
                        if (pick_found && GW'(i) == pick) s_arready[i] = 1'b1;
                    end
                end
                ADDR: m_arvalid = 1'b1;
                DATA: begin
                    for (int i = 0; i < N; i++) begin
                        if (GW'(i) == grant) begin
                            s_rvalid[i] = m_rvalid;
                            m_rready    = s_rready[i];
                        end
                    end
                    s_rdata = m_rdata;
                    s_rresp = m_rresp;
                    s_rlast = m_rlast;
                end
                default: ;
            endcase
        end
    end

    assign r_hs      = m_rvalid && m_rready;
    assign m_arburst = 2'b01;
    assign m_arid    = IDW'(grant);
    assign dbg_state = state;

    // State register and round-robin pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GW'(N - 1);
        end else begin
            state <= state_next;
            if (state == DATA && r_hs && m_rlast) last_grant <= grant;
        end
    end

    // Latch the grant and AR fields at capture; they stay frozen until the
    // next capture, so they are stable while m_arvalid is held
    always_ff @(posedge clock) begin
        if (reset) begin
            grant    <= '0;
            m_araddr <= '0;
            m_arlen  <= '0;
            m_arsize <= '0;
        end else if (state == IDLE && pick_found) begin
            grant    <= pick;
            m_araddr <= pick_addr;
            m_arlen  <= pick_len;
            m_arsize <= pick_size;
        end
    end

    // Beat counter: cleared when the address is accepted, bumped on each
    // R handshake, saturating so an overrun burst cannot wrap back to a
    // count that looks legal
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (state == ADDR && m_arready) begin
            beat_cnt <= '0;
        end else if (state == DATA && r_hs && beat_cnt != 9'h1FF) begin
            beat_cnt <= beat_cnt + 9'd1;
        end
    end

    // Sticky protocol-error flag: early/late rlast or a foreign rid
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == DATA && r_hs) begin
            if (m_rlast && beat_cnt != {1'b0, m_arlen}) err <= 1'b1;
            if (!m_rlast && beat_cnt >= {1'b0, m_arlen}) err <= 1'b1;
            if (m_rid != IDW'(grant)) err <= 1'b1;
        end
    end

endmodule
